// File: rtl/prv_trap_sequencer_pkg.sv
// Shared machine-mode types: trap cause codes, sequencer states, mtvec modes.
package machine_mode_types_pkg;

  localparam int unsigned EXC_W  = 9;
  localparam int unsigned CODE_W = 4;

  typedef enum logic [3:0] {
    EXC_MAL_INSN    = 4'd0,
    EXC_FAULT_INSN  = 4'd1,
    EXC_ILLEGAL     = 4'd2,
    EXC_BREAKPOINT  = 4'd3,
    EXC_MAL_LOAD    = 4'd4,
    EXC_FAULT_LOAD  = 4'd5,
    EXC_MAL_STORE   = 4'd6,
    EXC_FAULT_STORE = 4'd7,
    EXC_ENV_M       = 4'd11
  } exc_code_e;

  typedef enum logic [3:0] {
    INT_SOFT  = 4'd3,
    INT_TIMER = 4'd7,
    INT_EXT   = 4'd11
  } int_code_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_COMMIT,
    ST_RESTORE,
    ST_REDIRECT
  } trap_seq_state_t;

  typedef enum logic {
    KIND_TRAP,
    KIND_RET
  } trap_kind_e;

  localparam logic [1:0] MTVEC_MODE_DIRECT   = 2'd0;
  localparam logic [1:0] MTVEC_MODE_VECTORED = 2'd1;

endpackage

// File: rtl/prv_trap_sequencer_if.sv
// Event inputs and CSR/fetch outputs between hazard unit, sequencer and CSR file.
interface prv_trap_sequencer_if #(
  parameter int unsigned XLEN = 32
);
  logic [8:0]      exc_vec;
  logic            timer_int;
  logic            soft_int;
  logic            ext_int;
  logic [2:0]      mie_bits;
  logic            mstatus_mie;
  logic            mstatus_mpie;
  logic            ret;
  logic [XLEN-1:0] epc;
  logic [XLEN-1:0] badaddr;
  logic [XLEN-1:0] mtvec;
  logic [XLEN-1:0] mepc;
  logic            pipe_clear;
  logic            flush_req;
  logic [XLEN-1:0] mcause_next;
  logic [XLEN-1:0] mepc_next;
  logic [XLEN-1:0] mbadaddr_next;
  logic            mstatus_mie_next;
  logic            mstatus_mpie_next;
  logic            mcause_rup;
  logic            mepc_rup;
  logic            mbadaddr_rup;
  logic            mstatus_rup;
  logic            insert_pc;
  logic [XLEN-1:0] priv_pc;
  logic            busy;
  logic            drain_timeout;

  modport master (
    output exc_vec, timer_int, soft_int, ext_int, mie_bits, mstatus_mie, mstatus_mpie,
           ret, epc, badaddr, mtvec, mepc, pipe_clear,
    input  flush_req, mcause_next, mepc_next, mbadaddr_next, mstatus_mie_next,
           mstatus_mpie_next, mcause_rup, mepc_rup, mbadaddr_rup, mstatus_rup,
           insert_pc, priv_pc, busy, drain_timeout
  );

  modport slave (
    input  exc_vec, timer_int, soft_int, ext_int, mie_bits, mstatus_mie, mstatus_mpie,
           ret, epc, badaddr, mtvec, mepc, pipe_clear,
    output flush_req, mcause_next, mepc_next, mbadaddr_next, mstatus_mie_next,
           mstatus_mpie_next, mcause_rup, mepc_rup, mbadaddr_rup, mstatus_rup,
           insert_pc, priv_pc, busy, drain_timeout
  );
endinterface

// File: rtl/prv_trap_sequencer_cause_priority.sv
// Combinational priority encoder: raw exceptions and eligible interrupts to one cause.
module prv_cause_priority
  import machine_mode_types_pkg::*;
(
  input  logic [EXC_W-1:0]  exc_vec_i,
  input  logic [2:0]        int_elig_i,   // {ext, timer, soft}
  output logic              valid_c_o,
  output logic              intr_c_o,
  output logic [CODE_W-1:0] code_c_o
);

  // Exceptions in fixed order, then ext > soft > timer interrupts.
  always_comb begin
    valid_c_o = 1'b1;
    intr_c_o  = 1'b0;
    code_c_o  = '0;
    if (exc_vec_i[0])       code_c_o = EXC_BREAKPOINT;
    else if (exc_vec_i[1])  code_c_o = EXC_FAULT_INSN;
    else if (exc_vec_i[2])  code_c_o = EXC_MAL_INSN;
    else if (exc_vec_i[3])  code_c_o = EXC_ILLEGAL;
    else if (exc_vec_i[4])  code_c_o = EXC_ENV_M;
    else if (exc_vec_i[5])  code_c_o = EXC_MAL_STORE;
    else if (exc_vec_i[6])  code_c_o = EXC_MAL_LOAD;
    else if (exc_vec_i[7])  code_c_o = EXC_FAULT_STORE;
    else if (exc_vec_i[8])  code_c_o = EXC_FAULT_LOAD;
    else if (int_elig_i[2]) begin
      intr_c_o = 1'b1;
      code_c_o = INT_EXT;
    end else if (int_elig_i[0]) begin
      intr_c_o = 1'b1;
      code_c_o = INT_SOFT;
    end else if (int_elig_i[1]) begin
      intr_c_o = 1'b1;
      code_c_o = INT_TIMER;
    end else begin
      valid_c_o = 1'b0;
    end
  end

endmodule

// File: rtl/prv_trap_sequencer.sv
// Orders trap entry / mret into drain, CSR update strobes and a fetch redirect.
module prv_trap_sequencer
  import machine_mode_types_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned VECTORED_EN = 1,
  parameter int unsigned DRAIN_MAX   = 64
) (
  input  logic CLK,
  input  logic nRST,
  prv_trap_sequencer_if.slave bus
);

  localparam int unsigned CNT_W = (DRAIN_MAX > 2) ? $clog2(DRAIN_MAX) : 1;

  logic              pri_valid;
  logic              pri_intr;
  logic [CODE_W-1:0] pri_code;
  logic [2:0]        int_elig;

  trap_seq_state_t   state_q, state_d;
  trap_kind_e        kind_q, kind_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              intr_q, intr_d;
  logic [XLEN-1:0]   epc_q, epc_d, badaddr_q, badaddr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              timeout_q, timeout_d;

  logic              flush_q, flush_d, busy_q, busy_d;
  logic              mcause_rup_q, mcause_rup_d, mepc_rup_q, mepc_rup_d;
  logic              mbad_rup_q, mbad_rup_d, mstatus_rup_q, mstatus_rup_d;
  logic              insert_q, insert_d;
  logic              mie_next_q, mie_next_d, mpie_next_q, mpie_next_d;
  logic [XLEN-1:0]   mcause_q, mcause_d, mepc_next_q, mepc_next_d;
  logic [XLEN-1:0]   mbad_next_q, mbad_next_d, priv_pc_q, priv_pc_d;

  assign int_elig = {bus.ext_int & bus.mie_bits[2],
                     bus.timer_int & bus.mie_bits[1],
                     bus.soft_int & bus.mie_bits[0]} & {3{bus.mstatus_mie}};

  prv_cause_priority u_prio (
    .exc_vec_i (bus.exc_vec),
    .int_elig_i(int_elig),
    .valid_c_o (pri_valid),
    .intr_c_o  (pri_intr),
    .code_c_o  (pri_code)
  );

  // State, captured event and registered outputs.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q       <= ST_IDLE;
      kind_q        <= KIND_TRAP;
      code_q        <= '0;
      intr_q        <= 1'b0;
      epc_q         <= '0;
      badaddr_q     <= '0;
      cnt_q         <= '0;
      timeout_q     <= 1'b0;
      flush_q       <= 1'b0;
      busy_q        <= 1'b0;
      mcause_rup_q  <= 1'b0;
      mepc_rup_q    <= 1'b0;
      mbad_rup_q    <= 1'b0;
      mstatus_rup_q <= 1'b0;
      insert_q      <= 1'b0;
      mie_next_q    <= 1'b0;
      mpie_next_q   <= 1'b0;
      mcause_q      <= '0;
      mepc_next_q   <= '0;
      mbad_next_q   <= '0;
      priv_pc_q     <= '0;
    end else begin
      state_q       <= state_d;
      kind_q        <= kind_d;
      code_q        <= code_d;
      intr_q        <= intr_d;
      epc_q         <= epc_d;
      badaddr_q     <= badaddr_d;
      cnt_q         <= cnt_d;
      timeout_q     <= timeout_d;
      flush_q       <= flush_d;
      busy_q        <= busy_d;
      mcause_rup_q  <= mcause_rup_d;
      mepc_rup_q    <= mepc_rup_d;
      mbad_rup_q    <= mbad_rup_d;
      mstatus_rup_q <= mstatus_rup_d;
      insert_q      <= insert_d;
      mie_next_q    <= mie_next_d;
      mpie_next_q   <= mpie_next_d;
      mcause_q      <= mcause_d;
      mepc_next_q   <= mepc_next_d;
      mbad_next_q   <= mbad_next_d;
      priv_pc_q     <= priv_pc_d;
    end
  end

  // Next state, then outputs decoded from the state being entered so they register in step.
  always_comb begin
    state_d       = state_q;
    kind_d        = kind_q;
    code_d        = code_q;
    intr_d        = intr_q;
    epc_d         = epc_q;
    badaddr_d     = badaddr_q;
    cnt_d         = cnt_q;
    timeout_d     = timeout_q;
    flush_d       = 1'b0;
    mcause_rup_d  = 1'b0;
    mepc_rup_d    = 1'b0;
    mbad_rup_d    = 1'b0;
    mstatus_rup_d = 1'b0;
    insert_d      = 1'b0;
    mie_next_d    = mie_next_q;
    mpie_next_d   = mpie_next_q;
    mcause_d      = mcause_q;
    mepc_next_d   = mepc_next_q;
    mbad_next_d   = mbad_next_q;
    priv_pc_d     = priv_pc_q;

    case (state_q)
      ST_IDLE: begin
        if (pri_valid || bus.ret) begin
          kind_d    = pri_valid ? KIND_TRAP : KIND_RET;
          code_d    = pri_code;
          intr_d    = pri_valid & pri_intr;
          epc_d     = bus.epc;
          badaddr_d = bus.badaddr;
          state_d   = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (bus.pipe_clear) begin
          cnt_d   = '0;
          state_d = (kind_q == KIND_TRAP) ? ST_COMMIT : ST_RESTORE;
        end else if (cnt_q == CNT_W'(DRAIN_MAX - 1)) begin
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_COMMIT:   state_d = ST_REDIRECT;
      ST_RESTORE:  state_d = ST_REDIRECT;
      ST_REDIRECT: state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase

    case (state_d)
      ST_DRAIN: flush_d = 1'b1;
      ST_COMMIT: begin
        mcause_rup_d            = 1'b1;
        mepc_rup_d              = 1'b1;
        mstatus_rup_d           = 1'b1;
        mcause_d                = '0;
        mcause_d[XLEN-1]        = intr_q;
        mcause_d[CODE_W-1:0]    = code_q;
        mepc_next_d             = {epc_q[XLEN-1:2], 2'b00};
        mpie_next_d             = bus.mstatus_mie;
        mie_next_d              = 1'b0;
        if (!intr_q && (code_q inside {EXC_MAL_INSN, EXC_MAL_LOAD, EXC_FAULT_LOAD,
                                       EXC_MAL_STORE, EXC_FAULT_STORE})) begin
          mbad_rup_d  = 1'b1;
          mbad_next_d = badaddr_q;
        end
      end
      ST_RESTORE: begin
        mstatus_rup_d = 1'b1;
        mie_next_d    = bus.mstatus_mpie;
        mpie_next_d   = 1'b1;
      end
      ST_REDIRECT: begin
        insert_d = 1'b1;
        if (kind_q == KIND_RET) begin
          priv_pc_d = bus.mepc;
        end else if ((VECTORED_EN != 0) && (bus.mtvec[1:0] == MTVEC_MODE_VECTORED) && intr_q) begin
          priv_pc_d = {bus.mtvec[XLEN-1:2], 2'b00} + XLEN'({code_q, 2'b00});
        end else begin
          priv_pc_d = {bus.mtvec[XLEN-1:2], 2'b00};
        end
      end
      default: ;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  assign bus.flush_req         = flush_q;
  assign bus.busy              = busy_q;
  assign bus.drain_timeout     = timeout_q;
  assign bus.mcause_rup        = mcause_rup_q;
  assign bus.mepc_rup          = mepc_rup_q;
  assign bus.mbadaddr_rup      = mbad_rup_q;
  assign bus.mstatus_rup       = mstatus_rup_q;
  assign bus.insert_pc         = insert_q;
  assign bus.mstatus_mie_next  = mie_next_q;
  assign bus.mstatus_mpie_next = mpie_next_q;
  assign bus.mcause_next       = mcause_q;
  assign bus.mepc_next         = mepc_next_q;
  assign bus.mbadaddr_next     = mbad_next_q;
  assign bus.priv_pc           = priv_pc_q;

endmodule

// File: tb/tb_prv_trap_sequencer.sv
// Bench for prv_trap_sequencer: directed plan cases plus random events against a cause/priority model.
module tb_prv_trap_sequencer;
  localparam int unsigned XLEN = 32;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  int   errors = 0;
  int   checks = 0;

  prv_trap_sequencer_if #(.XLEN(XLEN)) bus ();

  prv_trap_sequencer #(.XLEN(XLEN), .VECTORED_EN(1), .DRAIN_MAX(64)) dut (
    .CLK (CLK),
    .nRST(nRST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit          trig;
    bit          is_ret;
    bit          intr;
    int unsigned code;
  } exp_t;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: walk causes from lowest to highest priority so the highest one present wins.
  function automatic exp_t model(input logic [8:0] ev, input logic ti, input logic si,
                                 input logic ei, input logic [2:0] mb, input logic gie,
                                 input logic r);
    int unsigned exc_code [9];
    exp_t x;
    exc_code = '{3, 1, 0, 2, 11, 6, 4, 7, 5};
    x = '{trig: 0, is_ret: 0, intr: 0, code: 0};
    if (r) begin x.trig = 1; x.is_ret = 1; end
    if (gie && ti && mb[1]) begin x = '{1, 0, 1, 7};  end
    if (gie && si && mb[0]) begin x = '{1, 0, 1, 3};  end
    if (gie && ei && mb[2]) begin x = '{1, 0, 1, 11}; end
    for (int i = 8; i >= 0; i--)
      if (ev[i]) x = '{1, 0, 0, exc_code[i]};
    return x;
  endfunction

  task automatic clear_events();
    bus.exc_vec = '0; bus.timer_int = 0; bus.soft_int = 0; bus.ext_int = 0; bus.ret = 0;
  endtask

  // One event: apply, release after capture, raise pipe_clear d cycles into DRAIN, check the outcome.
  task automatic txn(input string tag, input logic [8:0] ev, input logic ti, input logic si,
                     input logic ei, input logic r, input int d);
    exp_t x;
    int ins_cyc, n_mc, n_me, n_mb, n_ms, n_ins, overlap;
    logic [31:0] mc, me, mbv, pp, exp_pc;
    logic mie_n, mpie_n;
    ins_cyc = -1; n_mc = 0; n_me = 0; n_mb = 0; n_ms = 0; n_ins = 0; overlap = 0;
    mc = 0; me = 0; mbv = 0; pp = 0; mie_n = 0; mpie_n = 0;
    x = model(ev, ti, si, ei, bus.mie_bits, bus.mstatus_mie, r);
    bus.exc_vec = ev; bus.timer_int = ti; bus.soft_int = si; bus.ext_int = ei; bus.ret = r;
    bus.pipe_clear = 0;
    for (int k = 1; k <= 12 + d; k++) begin
      @(posedge CLK); #1;
      if (k == 1) clear_events();
      if (bus.mcause_rup) begin n_mc++; mc = bus.mcause_next; end
      if (bus.mepc_rup) begin n_me++; me = bus.mepc_next; end
      if (bus.mbadaddr_rup) begin n_mb++; mbv = bus.mbadaddr_next; end
      if (bus.mstatus_rup) begin
        n_ms++; mie_n = bus.mstatus_mie_next; mpie_n = bus.mstatus_mpie_next;
      end
      if (bus.insert_pc) begin
        n_ins++; ins_cyc = k; pp = bus.priv_pc;
        if (bus.mcause_rup | bus.mepc_rup | bus.mbadaddr_rup | bus.mstatus_rup) overlap++;
      end
      bus.pipe_clear = (k >= 1 + d);
    end
    chk({tag, ".busy_end"}, 32'(bus.busy), 32'd0);
    if (!x.trig) begin
      chk({tag, ".no_status"}, 32'(n_ms), 32'd0);
      chk({tag, ".no_insert"}, 32'(n_ins), 32'd0);
    end else begin
      chk({tag, ".n_insert"}, 32'(n_ins), 32'd1);
      chk({tag, ".ins_cyc"}, 32'(ins_cyc), 32'(3 + d));
      chk({tag, ".overlap"}, 32'(overlap), 32'd0);
      chk({tag, ".n_mstatus"}, 32'(n_ms), 32'd1);
      if (x.is_ret) begin
        chk({tag, ".n_mcause"}, 32'(n_mc), 32'd0);
        chk({tag, ".n_mepc"}, 32'(n_me), 32'd0);
        chk({tag, ".n_mbad"}, 32'(n_mb), 32'd0);
        chk({tag, ".mie_next"}, 32'(mie_n), 32'(bus.mstatus_mpie));
        chk({tag, ".mpie_next"}, 32'(mpie_n), 32'd1);
        chk({tag, ".priv_pc"}, pp, bus.mepc);
      end else begin
        exp_pc = {bus.mtvec[31:2], 2'b00};
        if (bus.mtvec[1:0] == 2'd1 && x.intr) exp_pc = exp_pc + 32'(x.code * 4);
        chk({tag, ".n_mcause"}, 32'(n_mc), 32'd1);
        chk({tag, ".mcause"}, mc, (x.intr ? 32'h8000_0000 : 32'h0) | 32'(x.code));
        chk({tag, ".n_mepc"}, 32'(n_me), 32'd1);
        chk({tag, ".mepc"}, me, bus.epc & ~32'h3);
        chk({tag, ".mie_next"}, 32'(mie_n), 32'd0);
        chk({tag, ".mpie_next"}, 32'(mpie_n), 32'(bus.mstatus_mie));
        if (!x.intr && (x.code inside {0, 4, 5, 6, 7})) begin
          chk({tag, ".n_mbad"}, 32'(n_mb), 32'd1);
          chk({tag, ".mbad"}, mbv, bus.badaddr);
        end else begin
          chk({tag, ".n_mbad"}, 32'(n_mb), 32'd0);
        end
        chk({tag, ".priv_pc"}, pp, exp_pc);
      end
    end
  endtask

  initial begin
    int first_rup, second_rup, seen;
    clear_events();
    bus.mie_bits = 0; bus.mstatus_mie = 0; bus.mstatus_mpie = 0;
    bus.epc = 0; bus.badaddr = 0; bus.mtvec = 0; bus.mepc = 0; bus.pipe_clear = 0;
    #22;
    chk("rst.busy", 32'(bus.busy), 32'd0);
    chk("rst.flush", 32'(bus.flush_req), 32'd0);
    chk("rst.insert", 32'(bus.insert_pc), 32'd0);
    chk("rst.mcause", bus.mcause_next, 32'd0);
    chk("rst.priv_pc", bus.priv_pc, 32'd0);
    @(negedge CLK); nRST = 1;

    bus.epc = 32'h100; bus.mtvec = 32'h2000;
    txn("illegal", 9'h008, 0, 0, 0, 0, 0);
    bus.badaddr = 32'h33;
    txn("mal_l_fault_insn", 9'h042, 0, 0, 0, 0, 0);
    bus.mie_bits = 3'b010; bus.mstatus_mie = 1; bus.mtvec = 32'h2001;
    txn("timer_vec", 9'h000, 1, 0, 0, 0, 0);
    bus.mstatus_mie = 0; bus.mstatus_mpie = 1; bus.mepc = 32'h440;
    txn("mret", 9'h000, 0, 0, 0, 1, 0);
    bus.mie_bits = 3'b111;
    txn("int_masked", 9'h000, 1, 1, 1, 0, 0);

    for (int n = 0; n < 40; n++) begin
      logic [8:0] ev;
      ev = ($urandom_range(0, 2) == 0) ? 9'h0 : 9'(1 << $urandom_range(0, 8));
      if ($urandom_range(0, 3) == 0) ev = ev | 9'(1 << $urandom_range(0, 8));
      bus.mie_bits = 3'($urandom); bus.mstatus_mie = 1'($urandom); bus.mstatus_mpie = 1'($urandom);
      bus.epc = $urandom; bus.badaddr = $urandom; bus.mtvec = $urandom; bus.mepc = $urandom;
      txn($sformatf("rnd%0d", n), ev, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
          int'($urandom_range(0, 3)));
    end

    // Held level: second trap accepted after one IDLE cycle.
    bus.mtvec = 32'h2000; first_rup = -1; second_rup = -1;
    bus.exc_vec = 9'h008; bus.pipe_clear = 1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge CLK); #1;
      if (k == 5) bus.exc_vec = 9'h0;
      if (k == 4) chk("b2b.idle_gap", 32'(bus.busy), 32'd0);
      if (bus.mcause_rup) begin
        if (first_rup < 0) first_rup = k; else second_rup = k;
      end
    end
    chk("b2b.first", 32'(first_rup), 32'd2);
    chk("b2b.second", 32'(second_rup), 32'd6);

    // Drain timeout: sticky flag, drain keeps requesting, then completes.
    bus.pipe_clear = 0; bus.exc_vec = 9'h008;
    @(posedge CLK); #1; clear_events();
    repeat (20) @(posedge CLK);
    #1 chk("to.early", 32'(bus.drain_timeout), 32'd0);
    repeat (50) @(posedge CLK);
    #1 chk("to.set", 32'(bus.drain_timeout), 32'd1);
    chk("to.flush", 32'(bus.flush_req), 32'd1);
    bus.pipe_clear = 1; seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge CLK); #1;
      if (bus.insert_pc) seen = 1;
    end
    chk("to.completes", 32'(seen), 32'd1);
    chk("to.sticky", 32'(bus.drain_timeout), 32'd1);

    // Reset during DRAIN.
    bus.pipe_clear = 0; bus.exc_vec = 9'h001;
    @(posedge CLK); #1; clear_events();
    @(posedge CLK); #2;
    chk("rmid.pre_busy", 32'(bus.busy), 32'd1);
    nRST = 0; #1;
    chk("rmid.busy", 32'(bus.busy), 32'd0);
    chk("rmid.flush", 32'(bus.flush_req), 32'd0);
    chk("rmid.timeout", 32'(bus.drain_timeout), 32'd0);
    chk("rmid.mcause", bus.mcause_next, 32'd0);
    chk("rmid.priv_pc", bus.priv_pc, 32'd0);
    @(negedge CLK); nRST = 1; bus.pipe_clear = 1; seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge CLK); #1;
      if (bus.mcause_rup | bus.mstatus_rup | bus.insert_pc | bus.busy) seen++;
    end
    chk("rmid.quiet", 32'(seen), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
